// File: rtl/pixel_map_pipe_if.sv
// Read/write bus of the perspective pixel mapper.
//   rd_en/rd_addr  : source-frame read strobe and address (mapper -> buffer)
//   rd_data        : source pixel, fixed latency after rd_en (buffer -> mapper)
//   wr_en/wr_addr/wr_data : destination write, held until wr_ready (mapper -> sink)
//   wr_ready       : sink accepts the write this cycle (sink -> mapper)
interface pixel_map_pipe_if #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 19
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ready;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, wr_ready
    );
endinterface

// File: rtl/pixel_map_pipe.sv
// Per-pixel perspective mapper. For each destination pixel (x, y) in raster
// order it computes src_x = (p1*x+p2*y+p3)/(p7*x+p8*y+p9) and
// src_y = (p4*x+p5*y+p6)/(same), fetches that source pixel and writes it out.
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : frame start pulse, accepted from IDLE only
//   p1..p9            : signed coefficients, sampled on an accepted start
//   bus (master)      : source read port and destination write port
//   busy, frame_done  : frame in progress / one-cycle end-of-frame pulse
module pixel_map_pipe #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int SRC_W  = 640,
    parameter int SRC_H  = 480,
    parameter int CW     = 79,
    parameter int QW     = 11,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2,
    parameter logic [PIX_W-1:0] BLACK = {PIX_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic signed [CW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9,
    pixel_map_pipe_if.master     bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int EW    = CW + QW + 1;
    localparam int CNT_W = $clog2(QW + 1) + 1;
    localparam int RLW   = $clog2(RD_LAT + 1) + 1;
    localparam int XW    = $clog2(H_RES + 1);
    localparam int YW    = $clog2(V_RES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RD, S_WR} state_t;

    state_t               state_r;
    logic signed [CW-1:0] c1_r, c2_r, c4_r, c5_r, c7_r, c8_r;
    logic signed [CW-1:0] nx_r, ny_r, d_r, rx_r, ry_r, rdn_r;
    logic [XW-1:0]        x_r;
    logic [YW-1:0]        y_r;
    logic [CNT_W-1:0]     div_cnt_r;
    logic [RLW-1:0]       rd_cnt_r;
    logic [CW-1:0]        xm_r, ym_r, dm_r;
    logic [QW-1:0]        qx_r, qy_r;
    logic                 inv_r;
    logic                 busy_r, frame_done_r, rd_en_r, wr_en_r;
    logic [ADDR_W-1:0]    rd_addr_r, wr_addr_r;
    logic [PIX_W-1:0]     wr_data_r;

    logic [CW-1:0]        nxm_s, nym_s, dm_s;
    logic                 inv0_s, gex_s, gey_s, oor_s;
    logic [CNT_W-1:0]     shamt_s;
    logic [EW-1:0]        dlim_s, dsh_s;
    logic [CW-1:0]        xm_nxt_s, ym_nxt_s;
    logic [QW-1:0]        qx_nxt_s, qy_nxt_s;
    logic [ADDR_W-1:0]    src_addr_s;

    // Magnitudes and validity of the current pixel's numerators/denominator
    always_comb begin
        nxm_s  = nx_r[CW-1] ? $unsigned(-nx_r) : $unsigned(nx_r);
        nym_s  = ny_r[CW-1] ? $unsigned(-ny_r) : $unsigned(ny_r);
        dm_s   = d_r[CW-1]  ? $unsigned(-d_r)  : $unsigned(d_r);
        dlim_s = EW'(dm_s) << QW;
        // a nonzero numerator whose sign differs from d gives a negative quotient
        inv0_s = (d_r == {CW{1'b0}})
              || ((nx_r != {CW{1'b0}}) && (nx_r[CW-1] != d_r[CW-1]))
              || ((ny_r != {CW{1'b0}}) && (ny_r[CW-1] != d_r[CW-1]))
              || (EW'(nxm_s) >= dlim_s)
              || (EW'(nym_s) >= dlim_s);
    end

    // One restoring-division step for both lanes, quotient MSB first
    always_comb begin
        shamt_s    = CNT_W'(QW) - div_cnt_r;
        dsh_s      = EW'(dm_r) << shamt_s;
        gex_s      = EW'(xm_r) >= dsh_s;
        gey_s      = EW'(ym_r) >= dsh_s;
        xm_nxt_s   = gex_s ? CW'(EW'(xm_r) - dsh_s) : xm_r;
        ym_nxt_s   = gey_s ? CW'(EW'(ym_r) - dsh_s) : ym_r;
        qx_nxt_s   = {qx_r[QW-2:0], gex_s};
        qy_nxt_s   = {qy_r[QW-2:0], gey_s};
        oor_s      = (qx_nxt_s >= QW'(SRC_W)) || (qy_nxt_s >= QW'(SRC_H));
        src_addr_s = ADDR_W'(qy_nxt_s) * ADDR_W'(SRC_W) + ADDR_W'(qx_nxt_s);
    end

    // Frame sequencer: divide, optional read, write with backpressure, advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            {c1_r, c2_r, c4_r, c5_r, c7_r, c8_r} <= {(6*CW){1'b0}};
            {nx_r, ny_r, d_r, rx_r, ry_r, rdn_r} <= {(6*CW){1'b0}};
            x_r          <= {XW{1'b0}};
            y_r          <= {YW{1'b0}};
            div_cnt_r    <= {CNT_W{1'b0}};
            rd_cnt_r     <= {RLW{1'b0}};
            xm_r         <= {CW{1'b0}};
            ym_r         <= {CW{1'b0}};
            dm_r         <= {CW{1'b0}};
            qx_r         <= {QW{1'b0}};
            qy_r         <= {QW{1'b0}};
            inv_r        <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            rd_en_r      <= 1'b0;
            wr_en_r      <= 1'b0;
            rd_addr_r    <= {ADDR_W{1'b0}};
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= {PIX_W{1'b0}};
        end else begin
            rd_en_r      <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // the frame_done cycle is already IDLE; a start there is dropped
                    if (start && !frame_done_r) begin
                        c1_r <= p1; c2_r <= p2; c4_r <= p4;
                        c5_r <= p5; c7_r <= p7; c8_r <= p8;
                        nx_r <= p3; rx_r <= p3;
                        ny_r <= p6; ry_r <= p6;
                        d_r  <= p9; rdn_r <= p9;
                        x_r  <= {XW{1'b0}};
                        y_r  <= {YW{1'b0}};
                        wr_addr_r <= {ADDR_W{1'b0}};
                        div_cnt_r <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (div_cnt_r == {CNT_W{1'b0}}) begin
                        xm_r      <= nxm_s;
                        ym_r      <= nym_s;
                        dm_r      <= dm_s;
                        inv_r     <= inv0_s;
                        qx_r      <= {QW{1'b0}};
                        qy_r      <= {QW{1'b0}};
                        div_cnt_r <= CNT_W'(1);
                    end else begin
                        xm_r <= xm_nxt_s;
                        ym_r <= ym_nxt_s;
                        qx_r <= qx_nxt_s;
                        qy_r <= qy_nxt_s;
                        if (div_cnt_r == CNT_W'(QW)) begin
                            div_cnt_r <= {CNT_W{1'b0}};
                            if (inv_r || oor_s) begin
                                wr_data_r <= BLACK;
                                wr_en_r   <= 1'b1;
                                state_r   <= S_WR;
                            end else begin
                                rd_addr_r <= src_addr_s;
                                rd_en_r   <= 1'b1;
                                rd_cnt_r  <= {RLW{1'b0}};
                                state_r   <= S_RD;
                            end
                        end else begin
                            div_cnt_r <= div_cnt_r + CNT_W'(1);
                        end
                    end
                end
                S_RD: begin
                    if (rd_cnt_r == RLW'(RD_LAT)) begin
                        wr_data_r <= bus.rd_data;
                        wr_en_r   <= 1'b1;
                        state_r   <= S_WR;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + RLW'(1);
                    end
                end
                S_WR: begin
                    if (bus.wr_ready) begin
                        wr_en_r <= 1'b0;
                        if (x_r < XW'(H_RES - 1)) begin
                            x_r       <= x_r + XW'(1);
                            nx_r      <= nx_r + c1_r;
                            ny_r      <= ny_r + c4_r;
                            d_r       <= d_r + c7_r;
                            wr_addr_r <= wr_addr_r + ADDR_W'(1);
                            state_r   <= S_DIV;
                        end else if (y_r < YW'(V_RES - 1)) begin
                            // new row: step the row-start values and restart from them
                            x_r       <= {XW{1'b0}};
                            y_r       <= y_r + YW'(1);
                            rx_r      <= rx_r + c2_r;
                            ry_r      <= ry_r + c5_r;
                            rdn_r     <= rdn_r + c8_r;
                            nx_r      <= rx_r + c2_r;
                            ny_r      <= ry_r + c5_r;
                            d_r       <= rdn_r + c8_r;
                            wr_addr_r <= wr_addr_r + ADDR_W'(1);
                            state_r   <= S_DIV;
                        end else begin
                            frame_done_r <= 1'b1;
                            busy_r       <= 1'b0;
                            state_r      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en   = rd_en_r;
    assign bus.rd_addr = rd_addr_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
endmodule

// File: tb/tb_pixel_map_pipe.sv
// Directed bench for pixel_map_pipe on a 4x3 destination / 4x3 source frame.
module tb_pixel_map_pipe;
    localparam int CW     = 32;
    localparam int QW     = 11;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 19;
    localparam int RD_LAT = 2;
    localparam int NPIX   = 12;
    localparam logic [7:0] B = 8'hFF;   // marks a pixel expected BLACK
    localparam int GAP_INV = QW + 2;
    localparam int GAP_VAL = QW + 1 + RD_LAT + 2;

    typedef struct packed {
        logic [8:0][CW-1:0]     p;     // p[k] is coefficient p(k+1)
        logic [NPIX-1:0][7:0]   src;   // expected source address per pixel
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic signed [CW-1:0] pv [9];
    logic                 busy, frame_done;
    logic [ADDR_W-1:0]    pipe_a [RD_LAT];
    int                   tests_run = 0;
    int                   tests_failed = 0;
    vec_t                 vecs [11];

    pixel_map_pipe_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    pixel_map_pipe #(
        .H_RES(4), .V_RES(3), .SRC_W(4), .SRC_H(3), .CW(CW), .QW(QW),
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BLACK(12'h000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .p1(pv[0]), .p2(pv[1]), .p3(pv[2]), .p4(pv[3]), .p5(pv[4]),
        .p6(pv[5]), .p7(pv[6]), .p8(pv[7]), .p9(pv[8]),
        .bus(bus), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] pix_of(input logic [ADDR_W-1:0] a);
        return PIX_W'((a * 19'd7) + 19'd3);
    endfunction

    // Fixed-latency source memory; addresses outside an rd_en cycle return junk
    always @(posedge clk) begin
        pipe_a[0] <= bus.rd_en ? bus.rd_addr : {ADDR_W{1'b1}};
        for (int k = 1; k < RD_LAT; k++) pipe_a[k] <= pipe_a[k-1];
    end
    assign bus.rd_data = pix_of(pipe_a[RD_LAT-1]);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_coefs(input vec_t v);
        for (int k = 0; k < 9; k++) pv[k] = v.p[k];
    endtask

    task automatic zero_coefs();
        for (int k = 0; k < 9; k++) pv[k] = {CW{1'b0}};
    endtask

    task automatic outputs_zero(input string nm);
        check({nm, " busy"}, busy, 0);
        check({nm, " frame_done"}, frame_done, 0);
        check({nm, " rd_en"}, bus.rd_en, 0);
        check({nm, " rd_addr"}, bus.rd_addr, 0);
        check({nm, " wr_en"}, bus.wr_en, 0);
        check({nm, " wr_addr"}, bus.wr_addr, 0);
        check({nm, " wr_data"}, bus.wr_data, 0);
    endtask

    // Run one frame; 'extra' adds a 5-cycle stall on pixel 3, a start while
    // busy and a start in the frame_done cycle
    task automatic run_frame(input int id, input vec_t v, input bit extra);
        int cyc, wcnt, last_wr, rd_seen, stall_cnt, gap;
        bit done;
        logic [ADDR_W-1:0] rd_a, hold_a;
        logic [PIX_W-1:0]  hold_d;
        logic [7:0]        e;
        cyc = 0; wcnt = 0; last_wr = -1; rd_seen = 0; stall_cnt = 0; done = 1'b0;
        rd_a = '0; hold_a = '0; hold_d = '0;
        @(negedge clk);
        set_coefs(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        zero_coefs();   // coefficients must already be latched
        check($sformatf("v%0d busy after start", id), busy, 1);
        while (!done && cyc < 2000) begin
            start = extra && (cyc == 30);
            bus.wr_ready = 1'b1;
            if (extra && bus.wr_en && bus.wr_addr == 19'd3 && stall_cnt < 5) begin
                bus.wr_ready = 1'b0;
                if (stall_cnt == 0) begin
                    hold_a = bus.wr_addr;
                    hold_d = bus.wr_data;
                end else begin
                    check($sformatf("v%0d stall wr_en", id), bus.wr_en, 1);
                    check($sformatf("v%0d stall wr_addr", id), bus.wr_addr, hold_a);
                    check($sformatf("v%0d stall wr_data", id), bus.wr_data, hold_d);
                end
                stall_cnt++;
            end
            if (bus.rd_en) begin
                rd_seen++;
                rd_a = bus.rd_addr;
            end
            if (bus.wr_en && bus.wr_ready) begin
                e = (wcnt < NPIX) ? v.src[wcnt] : B;
                check($sformatf("v%0d px%0d wr_addr", id, wcnt), bus.wr_addr, wcnt);
                if (e == B) begin
                    check($sformatf("v%0d px%0d no read", id, wcnt), rd_seen, 0);
                    check($sformatf("v%0d px%0d black", id, wcnt), bus.wr_data, 0);
                    gap = GAP_INV;
                end else begin
                    check($sformatf("v%0d px%0d reads", id, wcnt), rd_seen, 1);
                    check($sformatf("v%0d px%0d rd_addr", id, wcnt), rd_a, e);
                    check($sformatf("v%0d px%0d wr_data", id, wcnt), bus.wr_data, pix_of(19'(e)));
                    gap = GAP_VAL;
                end
                if (extra && wcnt == 3) gap += 5;
                check($sformatf("v%0d px%0d cycles", id, wcnt), cyc - last_wr, gap);
                last_wr = cyc;
                rd_seen = 0;
                wcnt++;
            end
            if (frame_done) begin
                check($sformatf("v%0d frame_done writes", id), wcnt, NPIX);
                check($sformatf("v%0d frame_done timing", id), cyc, last_wr + 1);
                done = 1'b1;
                start = extra;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("v%0d frame completed", id), done, 1);
        check($sformatf("v%0d busy after frame", id), busy, 0);
        check($sformatf("v%0d frame_done pulse", id), frame_done, 0);
        if (extra) check($sformatf("v%0d stall cycles", id), stall_cnt, 5);
    endtask

    initial begin
        int n, fd_cnt;
        // pixel order in src literals runs 11 (left) down to 0 (right)
        for (int i = 0; i < 11; i++) vecs[i] = '0;
        vecs[0].p[0] = 32'd1; vecs[0].p[4] = 32'd1; vecs[0].p[8] = 32'd1;
        vecs[0].src = {8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        vecs[1] = vecs[0]; vecs[1].p[2] = {CW{1'b1}};
        vecs[1].src = {8'd10, 8'd9, 8'd8, B, 8'd6, 8'd5, 8'd4, B, 8'd2, 8'd1, 8'd0, B};
        vecs[2] = vecs[0]; vecs[2].p[8] = 32'd2;
        vecs[2].src = {8'd5, 8'd5, 8'd4, 8'd4, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
        vecs[3] = vecs[0]; vecs[3].p[8] = 32'd0;
        vecs[3].src = {NPIX{B}};
        vecs[4] = vecs[0]; vecs[4].p[0] = 32'd4096;
        vecs[4].src = {B, B, B, 8'd8, B, B, B, 8'd4, B, B, B, 8'd0};
        vecs[5].p[0] = {CW{1'b1}}; vecs[5].p[4] = {CW{1'b1}}; vecs[5].p[8] = {CW{1'b1}};
        vecs[5].src = vecs[0].src;
        vecs[6] = vecs[0]; vecs[6].p[8] = {CW{1'b1}};
        vecs[6].src = {B, B, B, B, B, B, B, B, B, B, B, 8'd0};
        vecs[7] = vecs[0]; vecs[7].p[0] = 32'd2;
        vecs[7].src = {B, B, 8'd10, 8'd8, B, B, 8'd6, 8'd4, B, B, 8'd2, 8'd0};
        vecs[8] = vecs[0]; vecs[8].p[1] = 32'd1;
        vecs[8].src = {B, B, 8'd11, 8'd10, B, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0};
        vecs[9] = vecs[0]; vecs[9].p[3] = 32'd1;
        vecs[9].src = {B, B, B, 8'd8, B, B, 8'd9, 8'd4, B, 8'd10, 8'd5, 8'd0};
        vecs[10] = vecs[0]; vecs[10].p[0] = 32'd4; vecs[10].p[6] = 32'd1;
        vecs[10].src = {8'd3, 8'd2, 8'd6, 8'd8, 8'd3, 8'd2, 8'd2, 8'd4, 8'd3, 8'd2, 8'd2, 8'd0};

        reset_n = 1'b0; start = 1'b0; bus.wr_ready = 1'b0;
        zero_coefs();
        repeat (3) @(negedge clk);
        outputs_zero("in reset");
        reset_n = 1'b1;
        @(negedge clk);
        outputs_zero("after release");

        for (int i = 0; i < 11; i++) run_frame(i, vecs[i], 1'b0);
        run_frame(11, vecs[0], 1'b1);

        // Reset in the middle of the read of pixel 5
        @(negedge clk);
        set_coefs(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        zero_coefs();
        bus.wr_ready = 1'b1;
        n = 0;
        while (!(bus.rd_en && bus.rd_addr == 19'd5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach read of pixel 5", n < 500, 1);
        @(negedge clk);
        check("pre-reset wr_addr", bus.wr_addr, 5);
        #2 reset_n = 1'b0;
        #1 outputs_zero("mid-RD reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        fd_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_done || busy) fd_cnt++;
        end
        check("no frame_done/busy after reset", fd_cnt, 0);
        run_frame(12, vecs[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
